// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the two-port memory arbiter.
// slave: arbiter view; master: requesters plus memory model view.
interface mem_bus_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [15:0] p0_addr;
    logic [7:0]  p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [7:0]  p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [15:0] p1_addr;
    logic [7:0]  p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [7:0]  p1_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory between two requesters, one access at a time.
// Write: gnt one cycle after sampling; read: rvalid MEM_LAT+2 cycles after sampling; losers wait in req.
module mem_bus_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    mem_bus_arbiter_if.slave bus_if,
    output logic             busy_o
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_chk
        $error("mem_bus_arbiter: MEM_LAT must be in 1..7");
    end

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        win_q, win_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            win_q       <= 1'b0;
            cnt_q       <= 3'd0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata0_q    <= 8'h00;
            rdata1_q    <= 8'h00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus_if.p0_req || bus_if.p1_req) begin
                    // On a tie the port that did not win last time goes first.
                    if (bus_if.p0_req && bus_if.p1_req) win_d = ~last_gnt_q;
                    else                                win_d = bus_if.p1_req;
                    last_gnt_d = win_d;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (state_d == ISSUE) begin
                    gnt_d[win_d] = 1'b1;
                    mem_en_d     = 1'b1;
                    if (win_d) begin
                        mem_we_d    = bus_if.p1_we;
                        mem_addr_d  = bus_if.p1_addr;
                        mem_wdata_d = bus_if.p1_wdata;
                    end else begin
                        mem_we_d    = bus_if.p0_we;
                        mem_addr_d  = bus_if.p0_addr;
                        mem_wdata_d = bus_if.p0_wdata;
                    end
                end
            end
            WAIT: begin
                if (state_d == RESP) begin
                    rvalid_d[win_q] = 1'b1;
                    if (win_q) rdata1_d = bus_if.mem_rdata;
                    else       rdata0_d = bus_if.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus_if.p0_gnt    = gnt_q[0];
    assign bus_if.p1_gnt    = gnt_q[1];
    assign bus_if.p0_rvalid = rvalid_q[0];
    assign bus_if.p1_rvalid = rvalid_q[1];
    assign bus_if.p0_rdata  = rdata0_q;
    assign bus_if.p1_rdata  = rdata1_q;
    assign bus_if.mem_en    = mem_en_q;
    assign bus_if.mem_we    = mem_we_q;
    assign bus_if.mem_addr  = mem_addr_q;
    assign bus_if.mem_wdata = mem_wdata_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one instance with MEM_LAT=1 (d0) and one with MEM_LAT=4 (d1),
// each behind a small memory model; expected grants/responses are queued at stimulus time.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bi1();
    mem_bus_arbiter_if bi4();
    logic busy [0:1];

    mem_bus_arbiter #(.MEM_LAT(1)) u_dut1 (.clk_i(clk), .reset_i(reset), .bus_if(bi1), .busy_o(busy[0]));
    mem_bus_arbiter #(.MEM_LAT(4)) u_dut4 (.clk_i(clk), .reset_i(reset), .bus_if(bi4), .busy_o(busy[1]));

    logic        req   [0:1][0:1];
    logic        we    [0:1][0:1];
    logic [15:0] addr  [0:1][0:1];
    logic [7:0]  wdata [0:1][0:1];
    logic        gnt   [0:1][0:1];
    logic        rvld  [0:1][0:1];
    logic [7:0]  rdata [0:1][0:1];
    logic        mem_en [0:1];
    logic        mem_we [0:1];
    logic [15:0] mem_addr [0:1];
    logic [7:0]  mem_wdata [0:1];
    logic [8:0]  pipe [0:1][0:3];

    assign bi1.p0_req = req[0][0];  assign bi1.p0_we = we[0][0];  assign bi1.p0_addr = addr[0][0];  assign bi1.p0_wdata = wdata[0][0];
    assign bi1.p1_req = req[0][1];  assign bi1.p1_we = we[0][1];  assign bi1.p1_addr = addr[0][1];  assign bi1.p1_wdata = wdata[0][1];
    assign bi4.p0_req = req[1][0];  assign bi4.p0_we = we[1][0];  assign bi4.p0_addr = addr[1][0];  assign bi4.p0_wdata = wdata[1][0];
    assign bi4.p1_req = req[1][1];  assign bi4.p1_we = we[1][1];  assign bi4.p1_addr = addr[1][1];  assign bi4.p1_wdata = wdata[1][1];

    assign gnt[0][0] = bi1.p0_gnt;  assign gnt[0][1] = bi1.p1_gnt;  assign gnt[1][0] = bi4.p0_gnt;  assign gnt[1][1] = bi4.p1_gnt;
    assign rvld[0][0] = bi1.p0_rvalid;  assign rvld[0][1] = bi1.p1_rvalid;
    assign rvld[1][0] = bi4.p0_rvalid;  assign rvld[1][1] = bi4.p1_rvalid;
    assign rdata[0][0] = bi1.p0_rdata;  assign rdata[0][1] = bi1.p1_rdata;
    assign rdata[1][0] = bi4.p0_rdata;  assign rdata[1][1] = bi4.p1_rdata;
    assign mem_en[0] = bi1.mem_en;  assign mem_we[0] = bi1.mem_we;  assign mem_addr[0] = bi1.mem_addr;  assign mem_wdata[0] = bi1.mem_wdata;
    assign mem_en[1] = bi4.mem_en;  assign mem_we[1] = bi4.mem_we;  assign mem_addr[1] = bi4.mem_addr;  assign mem_wdata[1] = bi4.mem_wdata;

    // Read data is only driven in the exact cycle it is due; any other cycle shows 8'hEE.
    assign bi1.mem_rdata = pipe[0][0][8] ? pipe[0][0][7:0] : 8'hEE;
    assign bi4.mem_rdata = pipe[1][3][8] ? pipe[1][3][7:0] : 8'hEE;

    typedef struct { logic [15:0] a; logic [7:0] v; } wr_t;
    typedef struct { int port; int cyc; logic we; logic [15:0] a; logic [7:0] wd; } gexp_t;
    typedef struct { int port; int cyc; logic [7:0] data; } rexp_t;

    wr_t   wlog0[$], wlog1[$];
    gexp_t q_g0[$], q_g1[$];
    rexp_t q_r0[$], q_r1[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] init_fn(input logic [15:0] a);
        case (a)
            16'h00FF: return 8'hA9;
            16'hFFFC: return 8'h00;
            16'h0010: return 8'h11;
            16'h0020: return 8'h22;
            16'h0042: return 8'h77;
            16'h1234: return 8'h99;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic [7:0] rd_val(input int d, input logic [15:0] a);
        logic [7:0] v;
        v = init_fn(a);
        if (d == 0) begin
            foreach (wlog0[i]) if (wlog0[i].a == a) v = wlog0[i].v;
        end else begin
            foreach (wlog1[i]) if (wlog1[i].a == a) v = wlog1[i].v;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d] && mem_we[d]) begin
                if (d == 0) wlog0.push_back('{a: mem_addr[d], v: mem_wdata[d]});
                else        wlog1.push_back('{a: mem_addr[d], v: mem_wdata[d]});
            end
            pipe[d][0] <= {mem_en[d] && !mem_we[d], rd_val(d, mem_addr[d])};
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec(input int d);
        return {17'b0, gnt[d][0], gnt[d][1], rvld[d][0], rvld[d][1], rdata[d][0], rdata[d][1],
                mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d], busy[d]};
    endfunction

    task automatic mon_gnt(input int d);
        gexp_t e;
        int    p;
        int    sz;
        p  = gnt[d][1] ? 1 : 0;
        sz = (d == 0) ? q_g0.size() : q_g1.size();
        check_eq($sformatf("d%0d_gnt_onehot", d), 64'(gnt[d][0] & gnt[d][1]), 0);
        if (sz == 0) begin
            check_eq($sformatf("d%0d_gnt_unexpected_p%0d", d, p), sz, 1);
        end else begin
            if (d == 0) e = q_g0.pop_front();
            else        e = q_g1.pop_front();
            check_eq($sformatf("d%0d_gnt_port", d), p, e.port);
            check_eq($sformatf("d%0d_gnt_cycle", d), cyc, e.cyc);
            check_eq($sformatf("d%0d_mem_en", d), mem_en[d], 1);
            check_eq($sformatf("d%0d_mem_we", d), mem_we[d], e.we);
            check_eq($sformatf("d%0d_mem_addr", d), mem_addr[d], e.a);
            if (e.we) check_eq($sformatf("d%0d_mem_wdata", d), mem_wdata[d], e.wd);
        end
    endtask

    task automatic mon_rv(input int d);
        rexp_t e;
        int    p;
        int    sz;
        p  = rvld[d][1] ? 1 : 0;
        sz = (d == 0) ? q_r0.size() : q_r1.size();
        check_eq($sformatf("d%0d_rvalid_onehot", d), 64'(rvld[d][0] & rvld[d][1]), 0);
        if (sz == 0) begin
            check_eq($sformatf("d%0d_rvalid_unexpected_p%0d", d, p), sz, 1);
        end else begin
            if (d == 0) e = q_r0.pop_front();
            else        e = q_r1.pop_front();
            check_eq($sformatf("d%0d_rvalid_port", d), p, e.port);
            check_eq($sformatf("d%0d_rvalid_cycle", d), cyc, e.cyc);
            check_eq($sformatf("d%0d_rdata", d), rdata[d][p], e.data);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (gnt[d][0] || gnt[d][1])   mon_gnt(d);
            if (rvld[d][0] || rvld[d][1]) mon_rv(d);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int d, input int p, input logic w, input logic [15:0] a, input logic [7:0] wd);
        req[d][p]   = 1'b1;
        we[d][p]    = w;
        addr[d][p]  = a;
        wdata[d][p] = wd;
    endtask

    task automatic push_g(input int d, input int p, input int c, input logic w, input logic [15:0] a, input logic [7:0] wd);
        if (d == 0) q_g0.push_back('{port: p, cyc: c, we: w, a: a, wd: wd});
        else        q_g1.push_back('{port: p, cyc: c, we: w, a: a, wd: wd});
    endtask

    task automatic push_r(input int d, input int p, input int c, input logic [7:0] v);
        if (d == 0) q_r0.push_back('{port: p, cyc: c, data: v});
        else        q_r1.push_back('{port: p, cyc: c, data: v});
    endtask

    task automatic wait_gnt(input int d, input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (gnt[d][p]) seen = 1'b1;
        end
        req[d][p] = 1'b0;
        check_eq($sformatf("d%0d_p%0d_gnt_wait", d, p), seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int bc;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = 16'h0; wdata[d][p] = 8'h0;
            end
        end
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        check_eq("reset_outputs_d0", out_vec(0), 0);
        check_eq("reset_outputs_d1", out_vec(1), 0);
        step(2);

        // Single read, MEM_LAT=1.
        c = cyc;
        set_req(0, 0, 1'b0, 16'h00FF, 8'h00);
        push_g(0, 0, c + 1, 1'b0, 16'h00FF, 8'h00);
        push_r(0, 0, c + 3, 8'hA9);
        wait_gnt(0, 0);
        step(5);
        check_eq("rdata_hold_p0", rdata[0][0], 8'hA9);

        // Single write from p1.
        c = cyc;
        set_req(0, 1, 1'b1, 16'h8000, 8'h5A);
        push_g(0, 1, c + 1, 1'b1, 16'h8000, 8'h5A);
        wait_gnt(0, 1);
        check_eq("write_busy_issue", busy[0], 1);
        step(1);
        check_eq("write_busy_after", busy[0], 0);
        step(3);

        // Write then read the same address.
        c = cyc;
        set_req(0, 0, 1'b1, 16'h0200, 8'h3C);
        push_g(0, 0, c + 1, 1'b1, 16'h0200, 8'h3C);
        push_g(0, 0, c + 3, 1'b0, 16'h0200, 8'h00);
        push_r(0, 0, c + 5, 8'h3C);
        wait_gnt(0, 0);
        set_req(0, 0, 1'b0, 16'h0200, 8'h00);
        wait_gnt(0, 0);
        step(5);

        // MEM_LAT=4 read from p1, with p0 raised mid-WAIT.
        c  = cyc;
        bc = 0;
        set_req(1, 1, 1'b0, 16'hFFFC, 8'h00);
        push_g(1, 1, c + 1, 1'b0, 16'hFFFC, 8'h00);
        push_r(1, 1, c + 6, 8'h00);
        push_g(1, 0, c + 8, 1'b0, 16'h0042, 8'h00);
        push_r(1, 0, c + 13, 8'h77);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i <= 6) bc += int'(busy[1]);
            if (i == 1) req[1][1] = 1'b0;
            if (i == 3) set_req(1, 0, 1'b0, 16'h0042, 8'h00);
            if (i == 7) check_eq("lat4_busy_low", busy[1], 0);
            if (i == 8) req[1][0] = 1'b0;
        end
        check_eq("lat4_busy_cycles", bc, 6);
        step(8);

        // Reset during WAIT aborts the read.
        c = cyc;
        set_req(0, 0, 1'b0, 16'h1234, 8'h00);
        push_g(0, 0, c + 1, 1'b0, 16'h1234, 8'h00);
        step(1);
        req[0][0] = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("abort_outputs_d0", out_vec(0), 0);
        check_eq("abort_outputs_d1", out_vec(1), 0);
        step(4);

        // Simultaneous requests right after reset: p0 first, then strict alternation.
        c = cyc;
        set_req(0, 0, 1'b0, 16'h0010, 8'h00);
        set_req(0, 1, 1'b0, 16'h0020, 8'h00);
        for (int k = 0; k < 4; k++) begin
            int p;
            p = k % 2;
            push_g(0, p, c + 1 + 4 * k, 1'b0, (p == 0) ? 16'h0010 : 16'h0020, 8'h00);
            push_r(0, p, c + 3 + 4 * k, (p == 0) ? 8'h11 : 8'h22);
        end
        step(13);
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        step(6);
        check_eq("alt_idle_after", busy[0], 0);

        check_eq("d0_gnt_drain", q_g0.size(), 0);
        check_eq("d0_rvalid_drain", q_r0.size(), 0);
        check_eq("d1_gnt_drain", q_g1.size(), 0);
        check_eq("d1_rvalid_drain", q_r1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
